// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage valid/ready immediate generator (sign/zero-extend, branch shift, upper placement)
// Ports: clk, rst_n (async active-low); flush (sync clear of both stages);
//        in_valid/in_ready/instr/sel/mode accept an operand into stage 1;
//        out_valid/out_ready/out_data/out_illegal/out_trunc present the stage-2 result.
module imm_extend_pipe #(
  parameter int DATA_W = 32,
  parameter int W_A    = 26,
  parameter int W_B    = 14,
  parameter int W_C    = 17,
  parameter int SHIFT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] instr,
  input  logic [1:0]        sel,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_illegal,
  output logic              out_trunc
);
  localparam int SW = $clog2(DATA_W + 1);
  localparam int EA = W_A < DATA_W ? W_A : DATA_W;
  localparam int EB = W_B < DATA_W ? W_B : DATA_W;
  localparam int EC = W_C < DATA_W ? W_C : DATA_W;
  // Width tags are stored as the distance from the field MSB to the word MSB.
  localparam logic [SW-1:0] SH_A = SW'(DATA_W - EA);
  localparam logic [SW-1:0] SH_B = SW'(DATA_W - EB);
  localparam logic [SW-1:0] SH_C = SW'(DATA_W - EC);
  logic              r1_valid, r1_ill, r2_valid, r2_ill, r2_trunc;
  logic [1:0]        r1_mode;
  logic [SW-1:0]     r1_sh;
  logic [DATA_W-1:0] r1_field, r2_data;
  logic              w_s1_adv, w_s2_adv, w_trunc;
  logic [SW-1:0]     w_sh;
  logic [DATA_W-1:0] w_field, w_up, w_sx, w_sb, w_res;
  always_comb begin
    w_s2_adv = !r2_valid || out_ready;
    w_s1_adv = !r1_valid || w_s2_adv;
    w_sh     = sel == 2'b00 ? SH_A : sel == 2'b01 ? SH_B : SH_C;
    w_field  = sel == 2'b11 ? '0 : instr & ({DATA_W{1'b1}} >> w_sh);
    // Left-aligning the field gives upper placement; an arithmetic shift back sign-extends it.
    w_up     = r1_field << r1_sh;
    w_sx     = $signed(w_up) >>> r1_sh;
    w_sb     = w_sx << SHIFT;
    // Bits were lost iff shifting back does not recover the sign-extended value.
    w_trunc  = !r1_ill && r1_mode == 2'b10 && (($signed(w_sb) >>> SHIFT) != $signed(w_sx));
    w_res    = r1_ill ? '0 :
               r1_mode == 2'b00 ? w_sx :
               r1_mode == 2'b01 ? r1_field :
               r1_mode == 2'b10 ? w_sb : w_up;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_ill   <= 1'b0;
      r1_mode  <= '0;
      r1_sh    <= '0;
      r1_field <= '0;
      r2_valid <= 1'b0;
      r2_data  <= '0;
      r2_ill   <= 1'b0;
      r2_trunc <= 1'b0;
    end else if (flush) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) r1_valid <= in_valid;
      if (in_valid && w_s1_adv) begin
        r1_field <= w_field;
        r1_sh    <= w_sh;
        r1_mode  <= mode;
        r1_ill   <= sel == 2'b11;
      end
      if (w_s2_adv) r2_valid <= r1_valid;
      if (r1_valid && w_s2_adv) begin
        r2_data  <= w_res;
        r2_ill   <= r1_ill;
        r2_trunc <= w_trunc;
      end
    end
  end
  assign in_ready    = w_s1_adv;
  assign out_valid   = r2_valid;
  assign out_data    = r2_data;
  assign out_illegal = r2_ill;
  assign out_trunc   = r2_trunc;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: table-driven scoreboard bench for imm_extend_pipe
module tb_imm_extend_pipe;
  typedef struct {
    logic [31:0] instr;
    logic [1:0]  sel;
    logic [1:0]  mode;
    logic [31:0] data;
    logic        ill;
    logic        trunc;
  } vec_t;
  typedef struct {
    logic [31:0] data;
    logic        ill;
    logic        trunc;
  } exp_t;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic [31:0] instr = '0;
  logic [1:0]  sel = '0, mode = '0;
  logic        in_ready, out_valid, out_illegal, out_trunc;
  logic [31:0] out_data;
  logic        v16 = 0;
  logic [15:0] instr16 = '0;
  logic        rdy16, ov16, oi16, ot16;
  logic [15:0] od16;
  exp_t        q[$];
  vec_t        vt[12];
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  imm_extend_pipe #(.DATA_W(32), .W_A(26), .W_B(14), .W_C(17), .SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .sel(sel), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_illegal(out_illegal), .out_trunc(out_trunc)
  );
  imm_extend_pipe #(.DATA_W(16), .W_A(10), .W_B(14), .W_C(17), .SHIFT(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(v16), .in_ready(rdy16),
    .instr(instr16), .sel(2'b10), .mode(2'b10), .out_valid(ov16), .out_ready(1'b1),
    .out_data(od16), .out_illegal(oi16), .out_trunc(ot16)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask
  task automatic send(input vec_t v);
    int k = 0;
    in_valid = 1; instr = v.instr; sel = v.sel; mode = v.mode;
    #1;
    while (!in_ready && k < 50) begin
      @(negedge clk); #1; k++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    else q.push_back('{v.data, v.ill, v.trunc});
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 50) begin
      @(negedge clk); k++;
    end
    chk("drain_empty", q.size(), 32'd0);
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && out_valid && out_ready && !flush) begin
      if (q.size() == 0) chk("spurious_output", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
        chk("out_trunc", {31'd0, out_trunc}, {31'd0, e.trunc});
      end
    end
  end
  initial begin
    #50000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end
  initial begin
    logic [15:0] t_in[3], t_out[3];
    logic        t_tr[3];
    vt[0]  = '{32'h02000000, 2'b00, 2'b00, 32'hFE000000, 1'b0, 1'b0};
    vt[1]  = '{32'hFC1FFFFF, 2'b00, 2'b00, 32'h001FFFFF, 1'b0, 1'b0};
    vt[2]  = '{32'h00002000, 2'b01, 2'b01, 32'h00002000, 1'b0, 1'b0};
    vt[3]  = '{32'h0001FFFF, 2'b10, 2'b10, 32'hFFFFFFFC, 1'b0, 1'b0};
    vt[4]  = '{32'h00010000, 2'b10, 2'b00, 32'hFFFF0000, 1'b0, 1'b0};
    vt[5]  = '{32'h00003FFF, 2'b01, 2'b11, 32'hFFFC0000, 1'b0, 1'b0};
    vt[6]  = '{32'h00000001, 2'b00, 2'b11, 32'h00000040, 1'b0, 1'b0};
    vt[7]  = '{32'h12345678, 2'b11, 2'b10, 32'h00000000, 1'b1, 1'b0};
    vt[8]  = '{32'h00000003, 2'b00, 2'b01, 32'h00000003, 1'b0, 1'b0};
    vt[9]  = '{32'h00002000, 2'b01, 2'b00, 32'hFFFFE000, 1'b0, 1'b0};
    vt[10] = '{32'h00003FFE, 2'b01, 2'b10, 32'hFFFFFFF8, 1'b0, 1'b0};
    vt[11] = '{32'hFFFE0001, 2'b10, 2'b11, 32'h00008000, 1'b0, 1'b0};
    t_in  = '{16'h4000, 16'h1000, 16'hF000};
    t_out = '{16'h0000, 16'h4000, 16'hC000};
    t_tr  = '{1'b1, 1'b0, 1'b0};
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_illegal", {31'd0, out_illegal}, 32'd0);
    chk("reset_out_trunc", {31'd0, out_trunc}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    #1 chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    foreach (vt[i]) send(vt[i]);
    drain();
    out_ready = 0; in_valid = 1; sel = 2'b01; mode = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      instr = k;
      if (k == 3) begin
        for (int s = 0; s < 2; s++) begin
          #1;
          chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
          chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
          chk("bp_hold_data", out_data, 32'd1);
          @(negedge clk);
        end
        out_ready = 1;
      end
      #1;
      chk("bp_accept", {31'd0, in_ready}, 32'd1);
      q.push_back('{k, 1'b0, 1'b0});
      @(negedge clk);
    end
    in_valid = 0;
    for (int s = 0; s < 2; s++) begin
      #1 chk("bp_back_to_back", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    drain();
    in_valid = 1; sel = 2'b00; mode = 2'b01; instr = 32'h5;
    @(negedge clk);
    instr = 32'h6;
    @(negedge clk);
    instr = 32'h7; flush = 1;
    #1 chk("flush_pre_valid", {31'd0, out_valid}, 32'd1);
    q.delete();
    @(negedge clk);
    flush = 0; in_valid = 0;
    for (int s = 0; s < 3; s++) begin
      #1 chk("flush_no_output", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    out_ready = 0; in_valid = 1; sel = 2'b00; mode = 2'b01; instr = 32'h55;
    @(negedge clk);
    instr = 32'h66;
    @(negedge clk);
    in_valid = 0;
    #1;
    chk("rst_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("rst_pre_data", out_data, 32'h55);
    #2 rst_n = 0;
    #1;
    chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_async_data", out_data, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1; out_ready = 1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_discarded", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    send('{32'h00000077, 2'b00, 2'b01, 32'h00000077, 1'b0, 1'b0});
    drain();
    for (int i = 0; i < 5; i++) begin
      v16 = i < 3;
      instr16 = i < 3 ? t_in[i] : 16'h0;
      #1;
      if (i >= 2) begin
        chk("w16_valid", {31'd0, ov16}, 32'd1);
        chk("w16_data", {16'd0, od16}, {16'd0, t_out[i-2]});
        chk("w16_trunc", {31'd0, ot16}, {31'd0, t_tr[i-2]});
        chk("w16_illegal", {31'd0, oi16}, 32'd0);
      end
      @(negedge clk);
    end
    v16 = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
